axi_ram_slave: RTL

//  Single-beat AXI3 slave memory sitting directly downstream of the CPU AXI bridge.

---
 rtl/axi_ram_slave_pkg.sv | 26 ++
 rtl/axi_ram_slave_ram_1r1w_be.sv | 31 +++
 rtl/axi_ram_slave.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_ram_slave_pkg.sv
// Shared AXI response codes, FSM encodings and request bundle
// for the single-beat AXI RAM slave.
package axi_ram_slave_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef struct packed {
    logic [3:0] id;
    logic       err;
  } req_t;

endpackage

// File: rtl/axi_ram_slave_ram_1r1w_be.sv
// Word-wide RAM, one synchronous read port and one
// byte-enabled write port; a same-edge read sees the old word.
module ram_1r1w_be #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wbe
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wbe[i]) begin
          mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/axi_ram_slave.sv
// Single-beat AXI3 RAM slave with independent read and write
// FSMs and programmable response latencies.
module axi_ram_slave
  import axi_ram_slave_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int RD_DELAY = 2,
  parameter int WR_DELAY = 1
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam logic [3:0] RD_CNT = 4'(RD_DELAY);
  localparam logic [3:0] WR_CNT = 4'(WR_DELAY);

  logic unused_bits;
  assign unused_bits = ^{arsize, awsize, wid,
                         araddr[31:ADDR_W+2], araddr[1:0],
                         awaddr[31:ADDR_W+2], awaddr[1:0]};

  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;
  logic [31:0]       ram_rdata;
  logic              ram_we;

  rd_state_t         r_state;
  rd_state_t         r_next;
  logic [3:0]        r_cnt;
  logic [3:0]        r_cnt_next;
  req_t              r_req;
  logic [ADDR_W-1:0] r_idx;
  logic              ar_hs;

  assign ar_hs = arvalid & arready;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= r_next;
      r_cnt   <= r_cnt_next;
      if (ar_hs) begin
        r_req.id  <= arid;
        r_req.err <= (arlen != 8'd0);
        r_idx     <= araddr[ADDR_W+1:2];
      end
    end
  end

  // The RAM is sampled on the edge that enters R_RESP, so
  // the word is ready exactly when rvalid rises.
  always_comb begin
    r_next     = r_state;
    r_cnt_next = r_cnt;
    ram_re     = 1'b0;
    ram_raddr  = r_idx;
    arready    = 1'b0;
    rvalid     = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        arready   = 1'b1;
        ram_raddr = araddr[ADDR_W+1:2];
        if (arvalid) begin
          if (RD_CNT == 4'd0) begin
            r_next = R_RESP;
            ram_re = 1'b1;
          end else begin
            r_next     = R_WAIT;
            r_cnt_next = RD_CNT;
          end
        end
      end
      R_WAIT: begin
        if (r_cnt == 4'd1) begin
          r_next     = R_RESP;
          r_cnt_next = 4'd0;
          ram_re     = 1'b1;
        end else if (r_cnt != 4'd0) begin
          r_cnt_next = r_cnt - 4'd1;
        end
      end
      R_RESP: begin
        rvalid = 1'b1;
        if (rready) begin
          r_next = R_IDLE;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign rlast = rvalid;
  assign rid   = rvalid ? r_req.id : 4'd0;
  assign rresp = (rvalid && r_req.err) ? AXI_RESP_SLVERR
                                       : AXI_RESP_OKAY;
  assign rdata = (rvalid && !r_req.err) ? ram_rdata : 32'd0;

  wr_state_t         w_state;
  wr_state_t         w_next;
  logic [3:0]        w_cnt;
  logic [3:0]        w_cnt_next;
  req_t              aw_req;
  logic [ADDR_W-1:0] aw_idx;
  logic              aw_held;
  logic              w_held;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;
  logic              w_last_q;
  logic              aw_hs;
  logic              w_hs;
  logic              b_hs;
  logic              commit;
  logic              b_err;

  assign awready = (w_state == W_IDLE) && !aw_held;
  assign wready  = (w_state == W_IDLE) && !w_held;
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;
  assign b_hs    = bvalid & bready;
  assign commit  = (w_state == W_IDLE) && aw_held && w_held;
  assign b_err   = aw_req.err || !w_last_q;
  assign ram_we  = commit && !b_err;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      w_state  <= W_IDLE;
      w_cnt    <= '0;
      aw_req   <= '0;
      aw_idx   <= '0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
      w_last_q <= 1'b0;
    end else begin
      w_state <= w_next;
      w_cnt   <= w_cnt_next;
      if (aw_hs) begin
        aw_held    <= 1'b1;
        aw_req.id  <= awid;
        aw_req.err <= (awlen != 8'd0);
        aw_idx     <= awaddr[ADDR_W+1:2];
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
        w_last_q <= wlast;
      end
      if (b_hs) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  always_comb begin
    w_next     = w_state;
    w_cnt_next = w_cnt;
    bvalid     = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        if (commit) begin
          if (WR_CNT == 4'd0) begin
            w_next = W_RESP;
          end else begin
            w_next     = W_WAIT;
            w_cnt_next = WR_CNT;
          end
        end
      end
      W_WAIT: begin
        if (w_cnt == 4'd1) begin
          w_next     = W_RESP;
          w_cnt_next = 4'd0;
        end else if (w_cnt != 4'd0) begin
          w_cnt_next = w_cnt - 4'd1;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) begin
          w_next = W_IDLE;
        end
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign bid   = bvalid ? aw_req.id : 4'd0;
  assign bresp = (bvalid && b_err) ? AXI_RESP_SLVERR
                                   : AXI_RESP_OKAY;

  ram_1r1w_be #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata),
    .we    (ram_we),
    .waddr (aw_idx),
    .wdata (w_data_q),
    .wbe   (w_strb_q)
  );

endmodule
